// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
//   Shared Wishbone definitions for the slave decoder and its address matcher.
//   - wb_state_e : transfer FSM encoding (IDLE / FWD / RESP / ERR)
//   - WB_AW, WB_DW, WB_SELW : bus address, data and byte-select widths
//   - WB_ERR_DATA : default read data returned with an error response
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  localparam logic [WB_DW-1:0] WB_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } wb_state_e;

endpackage : wb_pkg

// File: rtl/wb_addr_match.sv
// ---------------------------------------------------------------------------
// wb_addr_match
//   Combinational priority address decoder. Slave i matches when
//   (addr & MASK_i) == BASE_i; when several slaves match, the lowest index
//   wins, so overlapping windows are resolved by port order.
// Ports
//   addr : input  address to decode
//   hit  : output 1 when at least one slave window matches
//   idx  : output index of the winning slave (0 when no hit)
// ---------------------------------------------------------------------------
module wb_addr_match
  import wb_pkg::*;
#(
  parameter int                     NSLV     = 4,
  parameter int                     IW       = 2,
  parameter logic [WB_AW*NSLV-1:0]  SLV_BASE = '0,
  parameter logic [WB_AW*NSLV-1:0]  SLV_MASK = '0
) (
  input  logic [WB_AW-1:0] addr,
  output logic             hit,
  output logic [IW-1:0]    idx
);

  // Scan from the highest index down so the last assignment, and therefore
  // the winner, is the lowest matching index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[WB_AW*i +: WB_AW]) == SLV_BASE[WB_AW*i +: WB_AW]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule : wb_addr_match

// File: rtl/wb_slave_decoder_n.sv
// ---------------------------------------------------------------------------
// wb_slave_decoder_n
//   Connects one pipelined Wishbone master to NSLV slaves. A request is
//   accepted only in IDLE, its address is decoded and registered together
//   with we/addr/data/sel, and the transfer is forwarded to the selected
//   slave. A watchdog aborts transfers that take TIMEOUT forwarding cycles;
//   unmapped addresses and timeouts produce an error response and are
//   recorded in o_err_sticky / o_err_addr. Only one transfer is outstanding.
// Ports
//   i_clk, in_rst             clock, asynchronous active-low reset
//   i_wb_cyc/stb/we/addr/data/sel  master request
//   o_wb_stall/ack/err/data   master response (ack/err are one-cycle pulses)
//   o_wb_s_cyc/stb            per-slave cycle and strobe
//   o_wb_s_we/addr/data/sel   registered request broadcast to all slaves
//   i_wb_s_stall/ack/data     per-slave response, slave i data at [32*i+:32]
//   o_err_sticky, o_err_addr  error flag and address of last errored transfer
//   i_err_clr                 clears o_err_sticky (a new error wins)
// ---------------------------------------------------------------------------
module wb_slave_decoder_n
  import wb_pkg::*;
#(
  parameter int                     NSLV       = 4,
  parameter logic [WB_AW*NSLV-1:0]  SLV_BASE   = {NSLV{32'h0}},
  parameter logic [WB_AW*NSLV-1:0]  SLV_MASK   = {NSLV{32'h0}},
  parameter int                     TIMEOUT    = 255,
  parameter logic [WB_DW-1:0]       ERR_DATA   = WB_ERR_DATA,
  parameter bit                     ERR_AS_ACK = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     in_rst,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [WB_AW-1:0]         i_wb_addr,
  input  logic [WB_DW-1:0]         i_wb_data,
  input  logic [WB_SELW-1:0]       i_wb_sel,
  output logic                     o_wb_stall,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  output logic [WB_DW-1:0]         o_wb_data,
  output logic [NSLV-1:0]          o_wb_s_cyc,
  output logic [NSLV-1:0]          o_wb_s_stb,
  output logic                     o_wb_s_we,
  output logic [WB_AW-1:0]         o_wb_s_addr,
  output logic [WB_DW-1:0]         o_wb_s_data,
  output logic [WB_SELW-1:0]       o_wb_s_sel,
  input  logic [NSLV-1:0]          i_wb_s_stall,
  input  logic [NSLV-1:0]          i_wb_s_ack,
  input  logic [WB_DW*NSLV-1:0]    i_wb_s_data,
  output logic                     o_err_sticky,
  output logic [WB_AW-1:0]         o_err_addr,
  input  logic                     i_err_clr
);

  localparam int IW  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  // Registered state
  wb_state_e            state_q,    state_d;
  logic [IW-1:0]        idx_q,      idx_d;
  logic                 we_q,       we_d;
  logic [WB_AW-1:0]     addr_q,     addr_d;
  logic [WB_DW-1:0]     wdata_q,    wdata_d;
  logic [WB_SELW-1:0]   sel_q,      sel_d;
  logic [NSLV-1:0]      s_cyc_q,    s_cyc_d;
  logic [NSLV-1:0]      s_stb_q,    s_stb_d;
  logic [WDW-1:0]       wd_q,       wd_d;
  logic                 ack_q,      ack_d;
  logic                 err_q,      err_d;
  logic [WB_DW-1:0]     rdata_q,    rdata_d;
  logic                 sticky_q,   sticky_d;
  logic [WB_AW-1:0]     err_addr_q, err_addr_d;

  // Combinational helpers
  logic                 dec_hit;
  logic [IW-1:0]        dec_idx;
  logic [NSLV-1:0]      dec_onehot;
  logic                 sel_ack;
  logic                 sel_stall;
  logic [WB_DW-1:0]     sel_rdata;
  logic [WDW-1:0]       wd_inc;
  logic                 set_err;

  wb_addr_match #(
    .NSLV     (NSLV),
    .IW       (IW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_addr_match (
    .addr (i_wb_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Select the latched slave's response; every other slave is ignored.
  always_comb begin
    sel_ack    = 1'b0;
    sel_stall  = 1'b0;
    sel_rdata  = '0;
    dec_onehot = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ack   = i_wb_s_ack[i];
        sel_stall = i_wb_s_stall[i];
        sel_rdata = i_wb_s_data[WB_DW*i +: WB_DW];
      end
      dec_onehot[i] = (dec_idx == IW'(i));
    end
  end

  assign wd_inc = wd_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    s_cyc_d    = s_cyc_q;
    s_stb_d    = s_stb_q;
    wd_d       = wd_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    set_err    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          we_d    = i_wb_we;
          addr_d  = i_wb_addr;
          wdata_d = i_wb_data;
          sel_d   = i_wb_sel;
          wd_d    = '0;
          if (dec_hit) begin
            state_d = ST_FWD;
            idx_d   = dec_idx;
            s_cyc_d = dec_onehot;
            s_stb_d = dec_onehot;
          end else begin
            // Unmapped: the error response is presented on the very next cycle.
            state_d    = ST_ERR;
            ack_d      = ERR_AS_ACK;
            err_d      = 1'b1;
            rdata_d    = ERR_DATA;
            err_addr_d = i_wb_addr;
            set_err    = 1'b1;
          end
        end
      end

      ST_FWD: begin
        if (!i_wb_cyc) begin
          // Master abandoned the cycle: release the slave silently.
          state_d = ST_IDLE;
          s_cyc_d = '0;
          s_stb_d = '0;
        end else if (sel_ack) begin
          // An ack on the final watchdog cycle still completes normally.
          state_d = ST_RESP;
          ack_d   = 1'b1;
          rdata_d = sel_rdata;
          s_cyc_d = '0;
          s_stb_d = '0;
        end else if (wd_inc == WDW'(TIMEOUT)) begin
          state_d    = ST_ERR;
          wd_d       = wd_inc;
          ack_d      = ERR_AS_ACK;
          err_d      = 1'b1;
          rdata_d    = ERR_DATA;
          err_addr_d = addr_q;
          set_err    = 1'b1;
          s_cyc_d    = '0;
          s_stb_d    = '0;
        end else begin
          wd_d = wd_inc;
          // Strobe is held until the slave accepts it (stall low), then dropped
          // while cyc stays up waiting for the ack.
          if (!sel_stall) begin
            s_stb_d = '0;
          end
        end
      end

      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new error takes priority over a clear request in the same cycle.
    if (set_err) begin
      sticky_d = 1'b1;
    end else if (i_err_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      s_cyc_q    <= '0;
      s_stb_q    <= '0;
      wd_q       <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      sticky_q   <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      s_cyc_q    <= s_cyc_d;
      s_stb_q    <= s_stb_d;
      wd_q       <= wd_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      sticky_q   <= sticky_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign o_wb_stall   = (state_q != ST_IDLE);
  assign o_wb_ack     = ack_q;
  assign o_wb_err     = err_q;
  assign o_wb_data    = rdata_q;
  assign o_wb_s_cyc   = s_cyc_q;
  assign o_wb_s_stb   = s_stb_q;
  assign o_wb_s_we    = we_q;
  assign o_wb_s_addr  = addr_q;
  assign o_wb_s_data  = wdata_q;
  assign o_wb_s_sel   = sel_q;
  assign o_err_sticky = sticky_q;
  assign o_err_addr   = err_addr_q;

endmodule : wb_slave_decoder_n

// File: tb/tb_wb_slave_decoder_n.sv
// ---------------------------------------------------------------------------
// tb_wb_slave_decoder_n
//   Directed bench for wb_slave_decoder_n (NSLV=4, TIMEOUT=8). Stimulus pushes
//   the expected master response (ack/err/data and cycle number) into a queue;
//   a monitor pops and compares whenever the DUT raises ack or err.
// ---------------------------------------------------------------------------
module tb_wb_slave_decoder_n;

  localparam int NSLV = 4;

  logic          clk = 1'b0;
  logic          in_rst;
  logic          wb_cyc, wb_stb, wb_we;
  logic [31:0]   wb_addr, wb_wdata;
  logic [3:0]    wb_sel;
  logic          wb_stall, wb_ack, wb_err;
  logic [31:0]   wb_rdata;
  logic [3:0]    s_cyc, s_stb;
  logic          s_we;
  logic [31:0]   s_addr, s_wdata;
  logic [3:0]    s_sel;
  logic [3:0]    s_stall, s_ack;
  logic [127:0]  s_rdata;
  logic          err_sticky;
  logic [31:0]   err_addr;
  logic          err_clr;

  wb_slave_decoder_n #(
    .NSLV       (NSLV),
    .SLV_BASE   ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK   ({4{32'hF000_0000}}),
    .TIMEOUT    (8),
    .ERR_DATA   (32'hDEAD_BEEF),
    .ERR_AS_ACK (1'b1)
  ) dut (
    .i_clk        (clk),
    .in_rst       (in_rst),
    .i_wb_cyc     (wb_cyc),
    .i_wb_stb     (wb_stb),
    .i_wb_we      (wb_we),
    .i_wb_addr    (wb_addr),
    .i_wb_data    (wb_wdata),
    .i_wb_sel     (wb_sel),
    .o_wb_stall   (wb_stall),
    .o_wb_ack     (wb_ack),
    .o_wb_err     (wb_err),
    .o_wb_data    (wb_rdata),
    .o_wb_s_cyc   (s_cyc),
    .o_wb_s_stb   (s_stb),
    .o_wb_s_we    (s_we),
    .o_wb_s_addr  (s_addr),
    .o_wb_s_data  (s_wdata),
    .o_wb_s_sel   (s_sel),
    .i_wb_s_stall (s_stall),
    .i_wb_s_ack   (s_ack),
    .i_wb_s_data  (s_rdata),
    .o_err_sticky (err_sticky),
    .o_err_addr   (err_addr),
    .i_err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        err;
    logic        ack;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc_n);
    end
  endtask

  task automatic push(input logic err, input logic ack, input logic [31:0] d, input int due);
    exp_t e;
    e.err  = err;
    e.ack  = ack;
    e.data = d;
    e.due  = due;
    sb.push_back(e);
  endtask

  // Monitor: every ack/err pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (in_rst && (wb_ack || wb_err)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got ack=%b err=%b data=%h want no response (cycle %0d)",
                 wb_ack, wb_err, wb_rdata, cyc_n);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_ack",   {31'd0, wb_ack}, {31'd0, mon_e.ack});
        chk("resp_err",   {31'd0, wb_err}, {31'd0, mon_e.err});
        chk("resp_data",  wb_rdata, mon_e.data);
        chk("resp_cycle", cyc_n, mon_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; returns during FWD cycle 1 with t0 = the stb cycle.
  task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int t0);
    @(posedge clk);
    #1;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_addr  = a;
    wb_wdata = d;
    wb_sel   = s;
    t0       = cyc_n;
    tick();
    wb_stb   = 1'b0;
  endtask

  task automatic finish_wait(input string name);
    int i = 0;
    while (sb.size() != 0 && i < 30) begin
      @(posedge clk);
      i++;
    end
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_no_resp: pending=%0d want 0", name, sb.size());
      sb.delete();
    end
    wb_cyc = 1'b0;
  endtask

  task automatic clear_sticky();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int stb_cnt;
    in_rst   = 1'b0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_addr  = '0;
    wb_wdata = '0;
    wb_sel   = '0;
    s_stall  = '0;
    s_ack    = '0;
    s_rdata  = '0;
    err_clr  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",  {31'd0, wb_stall},   32'd0);
    chk("rst_ack",    {31'd0, wb_ack},     32'd0);
    chk("rst_err",    {31'd0, wb_err},     32'd0);
    chk("rst_data",   wb_rdata,            32'd0);
    chk("rst_s_cyc",  {28'd0, s_cyc},      32'd0);
    chk("rst_s_stb",  {28'd0, s_stb},      32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_eaddr",  err_addr,            32'd0);
    tick();
    in_rst = 1'b1;

    // Read slave 2, ack 3 cycles after slave stb -> master ack at cycle 5
    start_req(1'b0, 32'h2000_0010, 32'h0, 4'hF, t0);
    push(1'b0, 1'b1, 32'hCAFE_F00D, t0 + 5);
    @(negedge clk);
    chk("rd_s_cyc",  {28'd0, s_cyc},    32'h4);
    chk("rd_s_stb",  {28'd0, s_stb},    32'h4);
    chk("rd_s_addr", s_addr,            32'h2000_0010);
    chk("rd_stall",  {31'd0, wb_stall}, 32'd1);
    repeat (3) tick();
    s_ack[2] = 1'b1;
    s_rdata[64 +: 32] = 32'hCAFE_F00D;
    tick();
    s_ack   = '0;
    s_rdata = '0;
    finish_wait("rd_slave2");

    // Write slave 1 with two stalled cycles -> stb high for 3 cycles
    s_stall[1] = 1'b1;
    start_req(1'b1, 32'h1000_0004, 32'h1234_5678, 4'b0011, t0);
    push(1'b0, 1'b1, 32'h5555_AAAA, t0 + 6);
    stb_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) s_stall[1] = 1'b0;
      if (c == 5) begin
        s_ack[1] = 1'b1;
        s_rdata[32 +: 32] = 32'h5555_AAAA;
      end
      @(negedge clk);
      if (s_stb[1]) stb_cnt++;
      if (c == 1) begin
        chk("wr_s_sel",  {28'd0, s_sel}, 32'h3);
        chk("wr_s_we",   {31'd0, s_we},  32'd1);
        chk("wr_s_data", s_wdata,        32'h1234_5678);
        chk("wr_s_addr", s_addr,         32'h1000_0004);
      end
      if (c == 4) chk("wr_s_cyc_only1", {28'd0, s_cyc}, 32'h2);
      tick();
    end
    s_ack   = '0;
    s_rdata = '0;
    chk("wr_stb_cycles", stb_cnt, 32'd3);
    finish_wait("wr_slave1");

    // Unmapped read -> error at cycle 1
    start_req(1'b0, 32'h5000_0000, 32'h0, 4'hF, t0);
    push(1'b1, 1'b1, 32'hDEAD_BEEF, t0 + 1);
    @(negedge clk);
    chk("unm_s_cyc", {28'd0, s_cyc}, 32'd0);
    finish_wait("unmapped");
    chk("unm_sticky", {31'd0, err_sticky}, 32'd1);
    chk("unm_eaddr",  err_addr,            32'h5000_0000);
    clear_sticky();
    chk("unm_sticky_clr", {31'd0, err_sticky}, 32'd0);

    // Watchdog: no ack -> err 9 cycles after stb
    start_req(1'b0, 32'h0000_0100, 32'h0, 4'hF, t0);
    push(1'b1, 1'b1, 32'hDEAD_BEEF, t0 + 9);
    repeat (7) tick();
    @(negedge clk);
    chk("wd_s_cyc_live", {28'd0, s_cyc}, 32'h1);
    tick();
    @(negedge clk);
    chk("wd_s_cyc_drop", {28'd0, s_cyc}, 32'd0);
    finish_wait("watchdog");
    chk("wd_eaddr",  err_addr,            32'h0000_0100);
    chk("wd_sticky", {31'd0, err_sticky}, 32'd1);
    clear_sticky();

    // Ack on the last watchdog cycle wins
    start_req(1'b0, 32'h0000_0200, 32'h0, 4'hF, t0);
    push(1'b0, 1'b1, 32'h0000_8888, t0 + 9);
    repeat (7) tick();
    s_ack[0] = 1'b1;
    s_rdata[0 +: 32] = 32'h0000_8888;
    tick();
    s_ack   = '0;
    s_rdata = '0;
    finish_wait("wd_late_ack");
    chk("late_ack_sticky", {31'd0, err_sticky}, 32'd0);

    // Master drops cyc mid-FWD -> silent abort, late ack ignored
    start_req(1'b0, 32'h3000_0000, 32'h0, 4'hF, t0);
    tick();
    wb_cyc = 1'b0;
    tick();
    s_ack[3] = 1'b1;
    @(negedge clk);
    chk("abort_s_cyc", {28'd0, s_cyc},    32'd0);
    chk("abort_s_stb", {28'd0, s_stb},    32'd0);
    chk("abort_stall", {31'd0, wb_stall}, 32'd0);
    tick();
    s_ack = '0;
    repeat (2) tick();

    // Ack in the same cycle as strobe acceptance
    start_req(1'b0, 32'h3000_0040, 32'h0, 4'hF, t0);
    s_ack[3] = 1'b1;
    s_rdata[96 +: 32] = 32'h3333_0001;
    push(1'b0, 1'b1, 32'h3333_0001, t0 + 2);
    tick();
    s_ack   = '0;
    s_rdata = '0;
    finish_wait("same_cycle_ack");

    // Reset mid-FWD -> slave side released immediately, no response
    start_req(1'b0, 32'h0000_0300, 32'h0, 4'hF, t0);
    tick();
    in_rst = 1'b0;
    #1;
    chk("rst_mid_s_cyc", {28'd0, s_cyc},    32'd0);
    chk("rst_mid_s_stb", {28'd0, s_stb},    32'd0);
    chk("rst_mid_stall", {31'd0, wb_stall}, 32'd0);
    tick();
    in_rst = 1'b1;
    wb_cyc = 1'b0;
    tick();
    start_req(1'b0, 32'h0000_0304, 32'h0, 4'hF, t0);
    push(1'b0, 1'b1, 32'h0101_0101, t0 + 3);
    tick();
    s_ack[0] = 1'b1;
    s_rdata[0 +: 32] = 32'h0101_0101;
    tick();
    s_ack   = '0;
    s_rdata = '0;
    finish_wait("after_reset");

    // Stray acks from unselected slaves are ignored
    start_req(1'b0, 32'h2000_0020, 32'h0, 4'hF, t0);
    push(1'b0, 1'b1, 32'h2222_0002, t0 + 5);
    tick();
    s_ack = 4'b0010;
    s_rdata[32 +: 32] = 32'hBAD0_BAD0;
    tick();
    s_ack = 4'b0011;
    tick();
    s_ack = 4'b0100;
    s_rdata[64 +: 32] = 32'h2222_0002;
    tick();
    s_ack   = '0;
    s_rdata = '0;
    finish_wait("stray_ack");

    // Error set wins over a simultaneous clear
    err_clr = 1'b1;
    start_req(1'b0, 32'h7000_0000, 32'h0, 4'hF, t0);
    err_clr = 1'b0;
    push(1'b1, 1'b1, 32'hDEAD_BEEF, t0 + 1);
    chk("set_wins_sticky", {31'd0, err_sticky}, 32'd1);
    finish_wait("set_wins");
    chk("set_wins_eaddr", err_addr, 32'h7000_0000);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_slave_decoder_n
